// File: rtl/vx_cache_wb_drain.sv
// Writeback drain buffer: queues dirty lines, serializes them into memory write beats
// (skipping clean beats), and answers address probes against lines still draining.
module vx_cache_wb_drain #(
   parameter int LINE_SIZE       = 16,
   parameter int MEM_DATA_SIZE   = 4,
   parameter int LINE_ADDR_WIDTH = 26,
   parameter int DEPTH           = 2,
   parameter int SKIP_EMPTY      = 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   evict_valid,
   output logic                                   evict_ready,
   input  logic [LINE_ADDR_WIDTH-1:0]             evict_addr,
   input  logic [LINE_SIZE*8-1:0]                 evict_data,
   input  logic [LINE_SIZE-1:0]                   evict_byteen,
   output logic                                   mem_req_valid,
   input  logic                                   mem_req_ready,
   output logic [LINE_ADDR_WIDTH+$clog2(LINE_SIZE/MEM_DATA_SIZE)-1:0] mem_req_addr,
   output logic [MEM_DATA_SIZE*8-1:0]             mem_req_data,
   output logic [MEM_DATA_SIZE-1:0]               mem_req_byteen,
   input  logic [LINE_ADDR_WIDTH-1:0]             lookup_addr,
   output logic                                   lookup_hit,
   output logic                                   empty
);

   localparam int BEATS     = LINE_SIZE / MEM_DATA_SIZE;
   localparam int BIDX_W    = $clog2(BEATS);
   localparam int BEAT_W    = (BIDX_W > 0) ? BIDX_W : 1;
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int BEAT_BITS = MEM_DATA_SIZE * 8;

   logic [LINE_ADDR_WIDTH-1:0] addr_q   [DEPTH];
   logic [LINE_SIZE*8-1:0]     data_q   [DEPTH];
   logic [LINE_SIZE-1:0]       byteen_q [DEPTH];

   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [BEAT_W-1:0] beat;

   logic                     is_empty;
   logic                     push;
   logic                     pop;
   logic                     advance;
   logic                     skip_adv;
   logic                     last_beat;
   logic [LINE_SIZE-1:0]     head_be;
   logic [LINE_SIZE*8-1:0]   head_data;
   logic [MEM_DATA_SIZE-1:0] beat_be;
   logic [DEPTH-1:0]         match;

   assign is_empty    = (count == '0);
   assign empty       = is_empty;
   assign evict_ready = (count != CNT_W'(DEPTH));
   assign push        = evict_valid && evict_ready;

   assign head_be   = byteen_q[rd_ptr];
   assign head_data = data_q[rd_ptr];
   assign beat_be   = head_be[int'(beat)*MEM_DATA_SIZE +: MEM_DATA_SIZE];

   // A clean beat is consumed silently in one cycle instead of waiting on memory.
   assign mem_req_valid = !is_empty && ((SKIP_EMPTY == 0) || (beat_be != '0));
   assign skip_adv      = (SKIP_EMPTY != 0) && !is_empty && (beat_be == '0);
   assign advance       = (mem_req_valid && mem_req_ready) || skip_adv;
   assign last_beat     = (beat == BEAT_W'(BEATS - 1));
   assign pop           = advance && last_beat;

   assign mem_req_data   = head_data[int'(beat)*BEAT_BITS +: BEAT_BITS];
   assign mem_req_byteen = beat_be;

   generate
      if (BIDX_W > 0) begin : g_multi_beat
         assign mem_req_addr = {addr_q[rd_ptr], beat};
      end else begin : g_single_beat
         assign mem_req_addr = addr_q[rd_ptr];
      end
   endgenerate

   // An entry is resident when its distance from the read pointer is below count.
   for (genvar i = 0; i < DEPTH; i++) begin : g_lookup
      logic [PTR_W-1:0] off;
      assign off      = PTR_W'(i) - rd_ptr;
      assign match[i] = ({1'b0, off} < count) && (addr_q[i] == lookup_addr);
   end
   assign lookup_hit = |match;

   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[wr_ptr]   <= evict_addr;
         data_q[wr_ptr]   <= evict_data;
         byteen_q[wr_ptr] <= evict_byteen;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         beat   <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (advance) beat <= last_beat ? '0 : beat + 1'b1;
      end
   end

endmodule

// File: tb/tb_vx_cache_wb_drain.sv
// Bench for vx_cache_wb_drain: line-level reference model plus a beat scoreboard,
// directed scenarios followed by randomized lines and memory backpressure.
module tb_vx_cache_wb_drain;

   localparam int LS    = 16;
   localparam int MDS   = 4;
   localparam int LAW   = 26;
   localparam int DEPTH = 2;
   localparam int BEATS = LS / MDS;

   logic             clk;
   logic             reset;
   logic             evict_valid;
   logic             evict_ready;
   logic [LAW-1:0]   evict_addr;
   logic [LS*8-1:0]  evict_data;
   logic [LS-1:0]    evict_byteen;
   logic             mem_req_valid;
   logic             mem_req_ready;
   logic [LAW+1:0]   mem_req_addr;
   logic [MDS*8-1:0] mem_req_data;
   logic [MDS-1:0]   mem_req_byteen;
   logic [LAW-1:0]   lookup_addr;
   logic             lookup_hit;
   logic             empty;

   vx_cache_wb_drain #(
      .LINE_SIZE(LS), .MEM_DATA_SIZE(MDS), .LINE_ADDR_WIDTH(LAW),
      .DEPTH(DEPTH), .SKIP_EMPTY(1)
   ) dut (
      .clk(clk), .reset(reset),
      .evict_valid(evict_valid), .evict_ready(evict_ready),
      .evict_addr(evict_addr), .evict_data(evict_data), .evict_byteen(evict_byteen),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_byteen(mem_req_byteen),
      .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .empty(empty)
   );

   typedef struct {
      logic [LAW-1:0]  addr;
      logic [LS*8-1:0] data;
      logic [LS-1:0]   be;
   } line_t;

   // Reference state: resident lines in arrival order, current beat of the head,
   // and the expected memory beats {addr, data, byteen}.
   line_t        mq[$];
   int           mbeat;
   logic [63:0]  exp_q[$];

   int           vectors;
   int           miscompares;
   int           rdy_pct;
   logic [LAW-1:0] last_addr;

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [MDS-1:0] beat_mask(input line_t l, input int b);
      return l.be[b*MDS +: MDS];
   endfunction

   // ---------------- drivers ----------------
   initial begin
      mem_req_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         mem_req_ready = ($urandom_range(99) < rdy_pct);
      end
   end

   initial begin
      lookup_addr = '0;
      forever begin
         @(posedge clk);
         #2;
         case ($urandom_range(3))
            0:       lookup_addr = last_addr;
            1:       lookup_addr = last_addr + 1'b1;
            2:       lookup_addr = evict_addr;
            default: lookup_addr = LAW'($urandom_range(7));
         endcase
      end
   end

   task automatic push_line(input logic [LAW-1:0] a, input logic [LS*8-1:0] d,
                            input logic [LS-1:0] be);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      evict_valid  = 1'b1;
      evict_addr   = a;
      evict_data   = d;
      evict_byteen = be;
      last_addr    = a;
      while (!acc && n < 500) begin
         @(negedge clk);
         acc = evict_ready;
         @(posedge clk);
         #1;
         n++;
      end
      evict_valid = 1'b0;
      check("push_accept", 64'(acc), 64'd1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((mq.size() != 0 || exp_q.size() != 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_done", 64'(n < 300), 64'd1);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [LS*8-1:0] rand_data();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      bit          exp_hit;
      bit          exp_valid;
      bit          push_ok;
      logic [63:0] e;
      if (!reset) begin
         mq.delete();
         exp_q.delete();
         mbeat = 0;
      end
      exp_hit = 1'b0;
      foreach (mq[i]) if (mq[i].addr == lookup_addr) exp_hit = 1'b1;
      exp_valid = (mq.size() > 0) && (beat_mask(mq[0], mbeat) != '0);
      check("empty", 64'(empty), 64'(mq.size() == 0));
      check("evict_ready", 64'(evict_ready), 64'(mq.size() != DEPTH));
      check("lookup_hit", 64'(lookup_hit), 64'(exp_hit));
      check("mem_req_valid", 64'(mem_req_valid), 64'(exp_valid));

      if (mem_req_valid && mem_req_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_beat", {mem_req_addr, mem_req_data, mem_req_byteen}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("beat", {mem_req_addr, mem_req_data, mem_req_byteen}, e);
         end
      end

      if (reset) begin
         push_ok = evict_valid && (mq.size() != DEPTH);
         if (mq.size() > 0) begin
            if (beat_mask(mq[0], mbeat) == '0 || mem_req_ready) begin
               mbeat++;
               if (mbeat == BEATS) begin
                  void'(mq.pop_front());
                  mbeat = 0;
               end
            end
         end
         if (push_ok) begin
            line_t l;
            l.addr = evict_addr;
            l.data = evict_data;
            l.be   = evict_byteen;
            mq.push_back(l);
            for (int b = 0; b < BEATS; b++) begin
               if (beat_mask(l, b) != '0)
                  exp_q.push_back({evict_addr, 2'(b), evict_data[b*MDS*8 +: MDS*8],
                                   beat_mask(l, b)});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      vectors      = 0;
      miscompares  = 0;
      rdy_pct      = 100;
      last_addr    = '0;
      reset        = 1'b0;
      evict_valid  = 1'b0;
      evict_addr   = '0;
      evict_data   = '0;
      evict_byteen = '0;

      repeat (3) @(posedge clk);
      #3;
      check("rst_evict_ready", 64'(evict_ready), 64'd1);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check("rst_lookup_hit", 64'(lookup_hit), 64'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // full line, streaming
      push_line(26'h10, rand_data(), 16'hFFFF);
      wait_idle();

      // sparse and fully clean lines
      push_line(26'h11, rand_data(), 16'h0F00);
      push_line(26'h12, rand_data(), 16'h0000);
      wait_idle();

      // backpressure mid-line
      push_line(26'h13, rand_data(), 16'hFFFF);
      @(posedge clk);
      #1;
      rdy_pct = 0;
      repeat (5) @(posedge clk);
      #1;
      rdy_pct = 100;
      wait_idle();

      // fill to capacity, third offer stalls until the first line drains
      rdy_pct = 0;
      push_line(26'h20, rand_data(), 16'hFFFF);
      push_line(26'h21, rand_data(), 16'hFFFF);
      fork
         push_line(26'h22, rand_data(), 16'hFFFF);
         begin
            repeat (4) @(posedge clk);
            #1;
            rdy_pct = 100;
         end
      join
      wait_idle();

      // asynchronous reset after the second beat of a line
      rdy_pct = 100;
      push_line(26'h33, rand_data(), 16'hFFFF);
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("arst_evict_ready", 64'(evict_ready), 64'd1);
      check("arst_empty", 64'(empty), 64'd1);
      check("arst_mem_req_valid", 64'(mem_req_valid), 64'd0);
      check("arst_lookup_hit", 64'(lookup_hit), 64'd0);
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      @(posedge clk);
      #1;
      wait_idle();

      // randomized lines with random masks and backpressure
      for (int n = 0; n < 150; n++) begin
         logic [LS-1:0] be;
         if (n % 20 == 0) rdy_pct = $urandom_range(30, 100);
         case ($urandom_range(3))
            0:       be = 16'hFFFF;
            1:       be = 16'h0000;
            2:       be = 16'($urandom());
            default: be = 16'h000F << (4 * $urandom_range(3));
         endcase
         push_line(LAW'($urandom_range(7)), rand_data(), be);
         repeat ($urandom_range(2)) begin
            @(posedge clk);
            #1;
         end
      end
      rdy_pct = 100;
      wait_idle();
      check("leftover_beats", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
